// File: rtl/arp_pkg.sv
// Shared ARP stream constants, receive FSM encoding and payload field unpacking.
package arp_pkg;

    localparam int          ARP_WORDS      = 7;
    localparam int          IDX_W          = $clog2(ARP_WORDS);
    localparam logic [15:0] ARP_OP_REQUEST = 16'd1;
    localparam logic [15:0] ARP_OP_REPLY   = 16'd2;

    // Word positions within the 28-byte payload, shared with arp_transm.
    localparam int W_TYPES   = 0;
    localparam int W_LEN_OP  = 1;
    localparam int W_SHA_HI  = 2;
    localparam int W_SHA_SPA = 3;
    localparam int W_SPA_THA = 4;
    localparam int W_THA_LO  = 5;
    localparam int W_TPA     = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_CHECK,
        ST_DRAIN
    } arp_state_e;

    typedef logic [ARP_WORDS-1:0][31:0] arp_words_t;

    typedef struct packed {
        logic [15:0] htype;
        logic [15:0] ptype;
        logic [7:0]  hlen;
        logic [7:0]  plen;
        logic [15:0] oper;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [47:0] tha;
        logic [31:0] tpa;
    } arp_fields_t;

    function automatic arp_fields_t arp_unpack(input arp_words_t w);
        arp_fields_t f;
        f.htype = w[W_TYPES][31:16];
        f.ptype = w[W_TYPES][15:0];
        f.hlen  = w[W_LEN_OP][31:24];
        f.plen  = w[W_LEN_OP][23:16];
        f.oper  = w[W_LEN_OP][15:0];
        f.sha   = {w[W_SHA_HI], w[W_SHA_SPA][31:16]};
        f.spa   = {w[W_SHA_SPA][15:0], w[W_SPA_THA][31:16]};
        f.tha   = {w[W_SPA_THA][15:0], w[W_THA_LO]};
        f.tpa   = w[W_TPA];
        return f;
    endfunction

endpackage

// File: rtl/arp_recv_if.sv
// Bus bundle for arp_recv: ARP word stream in, decoded fields and result strobes out.
// The ARP_IP_FILTER_EN build adds nothing here; local_ip_addr is a plain port on arp_recv.
interface arp_recv_if;
    logic [31:0] input_receive;
    logic        input_valid;
    logic [15:0] hdr_type;
    logic [15:0] proto_type;
    logic [15:0] operation;
    logic [47:0] send_hdr_addr;
    logic [31:0] send_ip_addr;
    logic [47:0] target_hdr_addr;
    logic [31:0] target_ip_addr;
    logic        is_request;
    logic        pkt_valid;
    logic        pkt_error;
    logic        busy;

    modport master (
        output input_receive, input_valid,
        input  hdr_type, proto_type, operation, send_hdr_addr, send_ip_addr,
               target_hdr_addr, target_ip_addr, is_request, pkt_valid, pkt_error, busy
    );

    modport slave (
        input  input_receive, input_valid,
        output hdr_type, proto_type, operation, send_hdr_addr, send_ip_addr,
               target_hdr_addr, target_ip_addr, is_request, pkt_valid, pkt_error, busy
    );
endinterface

// File: rtl/arp_word_sreg.sv
// Seven-word capture register for the ARP payload, written at an explicit word index.
module arp_word_sreg
    import arp_pkg::*;
(
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [31:0]      wr_data_i,
    output arp_words_t       words_o
);

    arp_words_t words_q;

    // NOTE: payload storage has no reset; every word is rewritten before CHECK reads it.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            words_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign words_o = words_q;

endmodule

// File: rtl/arp_recv.sv
// ARP receiver: collects 7 stream words, checks the fixed header, publishes fields with a result strobe.
// Defining ARP_IP_FILTER_EN adds local_ip_addr and silently drops packets addressed to another IP.
module arp_recv
    import arp_pkg::*;
#(
    parameter logic [15:0] EXP_HDR_TYPE   = 16'h0001,
    parameter logic [15:0] EXP_PROTO_TYPE = 16'h0800,
    parameter logic [7:0]  EXP_HLEN       = 8'd6,
    parameter logic [7:0]  EXP_PLEN       = 8'd4
) (
    input  logic        clk,
    input  logic        rst,
`ifdef ARP_IP_FILTER_EN
    input  logic [31:0] local_ip_addr,
`endif
    arp_recv_if.slave   bus
);

    arp_state_e       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    arp_fields_t      fields_q, fields_d, rx;
    logic             pkt_valid_q, pkt_valid_d;
    logic             pkt_error_q, pkt_error_d;
    logic             is_request_q, is_request_d;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    arp_words_t       words;
    logic             hdr_ok, op_ok, ip_ok;

    arp_word_sreg u_sreg (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_idx_i  (wr_idx),
        .wr_data_i (bus.input_receive),
        .words_o   (words)
    );

    assign rx     = arp_unpack(words);
    assign hdr_ok = (rx.htype == EXP_HDR_TYPE) && (rx.ptype == EXP_PROTO_TYPE) &&
                    (rx.hlen == EXP_HLEN) && (rx.plen == EXP_PLEN);
    assign op_ok  = (rx.oper == ARP_OP_REQUEST) || (rx.oper == ARP_OP_REPLY);
`ifdef ARP_IP_FILTER_EN
    assign ip_ok  = (rx.tpa == local_ip_addr);
`else
    assign ip_ok  = 1'b1;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        fields_d     = fields_q;
        pkt_valid_d  = 1'b0;
        pkt_error_d  = 1'b0;
        is_request_d = 1'b0;
        wr_en        = 1'b0;
        wr_idx       = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.input_valid) begin
                    wr_en   = 1'b1;
                    wr_idx  = '0;
                    cnt_d   = IDX_W'(1);
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                if (bus.input_valid) begin
                    wr_en = 1'b1;
                    if (cnt_q == IDX_W'(ARP_WORDS - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_CHECK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    // Truncated packet: flag it, keep the previously published fields.
                    pkt_error_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (!(hdr_ok && op_ok)) begin
                    fields_d    = rx;
                    pkt_error_d = 1'b1;
                end else if (ip_ok) begin
                    fields_d     = rx;
                    pkt_valid_d  = 1'b1;
                    is_request_d = (rx.oper == ARP_OP_REQUEST);
                end
                state_d = bus.input_valid ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (!bus.input_valid) begin
                    pkt_error_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            fields_q     <= '0;
            pkt_valid_q  <= 1'b0;
            pkt_error_q  <= 1'b0;
            is_request_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fields_q     <= fields_d;
            pkt_valid_q  <= pkt_valid_d;
            pkt_error_q  <= pkt_error_d;
            is_request_q <= is_request_d;
        end
    end

    assign bus.hdr_type        = fields_q.htype;
    assign bus.proto_type      = fields_q.ptype;
    assign bus.operation       = fields_q.oper;
    assign bus.send_hdr_addr   = fields_q.sha;
    assign bus.send_ip_addr    = fields_q.spa;
    assign bus.target_hdr_addr = fields_q.tha;
    assign bus.target_ip_addr  = fields_q.tpa;
    assign bus.is_request      = is_request_q;
    assign bus.pkt_valid       = pkt_valid_q;
    assign bus.pkt_error       = pkt_error_q;
    assign bus.busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_arp_recv.sv
// Self-checking bench for arp_recv: directed and random packets against a packet-level model.
// Build with ARP_IP_FILTER_EN defined to exercise the target-IP filter.
module tb_arp_recv;

    typedef logic [31:0] pkt_t [7];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] local_ip = 32'h0A000002;

    arp_recv_if bus();

    arp_recv dut (
        .clk           (clk),
        .rst           (rst),
`ifdef ARP_IP_FILTER_EN
        .local_ip_addr (local_ip),
`endif
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed strobes (cycle stamp = posedges seen so far) and expectations from the model.
    int          v_cyc[$], e_cyc[$], xv_cyc[$], xe_cyc[$];
    logic        v_req[$], xv_req[$];
    logic [31:0] v_tpa[$], xv_tpa[$];
    bit          both_seen, stray_req;

    // Model of the published fields.
    logic [15:0] m_htype, m_ptype, m_oper;
    logic [47:0] m_sha, m_tha;
    logic [31:0] m_spa, m_tpa;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.pkt_valid) begin
                v_cyc.push_back(cyc);
                v_req.push_back(bus.is_request);
                v_tpa.push_back(bus.target_ip_addr);
            end
            if (bus.pkt_error) e_cyc.push_back(cyc);
            if (bus.pkt_valid && bus.pkt_error) both_seen = 1'b1;
            if (bus.is_request && !bus.pkt_valid) stray_req = 1'b1;
        end
    end

    function automatic logic [207:0] dut_fields();
        return {bus.hdr_type, bus.proto_type, bus.operation, bus.send_hdr_addr,
                bus.send_ip_addr, bus.target_hdr_addr, bus.target_ip_addr};
    endfunction

    task automatic model_publish(input pkt_t w);
        m_htype = w[0][31:16];
        m_ptype = w[0][15:0];
        m_oper  = w[1][15:0];
        m_sha   = {w[2], w[3][31:16]};
        m_spa   = {w[3][15:0], w[4][31:16]};
        m_tha   = {w[4][15:0], w[5]};
        m_tpa   = w[6];
    endtask

    task automatic model_clear();
        {m_htype, m_ptype, m_oper, m_sha, m_spa, m_tha, m_tpa} = '0;
    endtask

    // Drives n valid cycles (words past the seventh are junk), then one low cycle; records expectations.
    task automatic drive_pkt(input pkt_t w, input int n);
        int   k;
        logic well, ip_match;
        @(posedge clk); #1;
        k = cyc;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            bus.input_valid   = 1'b1;
            bus.input_receive = (i < 7) ? w[i] : $urandom;
        end
        @(posedge clk); #1;
        bus.input_valid   = 1'b0;
        bus.input_receive = $urandom;

        if (n < 7) begin
            xe_cyc.push_back(k + n + 1);
        end else begin
            well = (w[0] == 32'h00010800) && (w[1][31:16] == 16'h0604) &&
                   (w[1][15:0] == 16'd1 || w[1][15:0] == 16'd2);
            ip_match = 1'b1;
`ifdef ARP_IP_FILTER_EN
            ip_match = (w[6] == local_ip);
`endif
            if (!well) begin
                xe_cyc.push_back(k + 8);
                model_publish(w);
            end else if (ip_match) begin
                xv_cyc.push_back(k + 8);
                xv_req.push_back(w[1][15:0] == 16'd1);
                xv_tpa.push_back(w[6]);
                model_publish(w);
            end
            if (n > 7) xe_cyc.push_back(k + n + 1);
        end
    endtask

    task automatic finish_check(input string name);
        logic [207:0] want;
        repeat (12) @(posedge clk);
        @(negedge clk);

        checks++;
        if (v_cyc.size() !== xv_cyc.size()) begin
            failures++;
            $display("FAIL %s pkt_valid count: got %0d want %0d", name, v_cyc.size(), xv_cyc.size());
        end else begin
            for (int i = 0; i < xv_cyc.size(); i++) begin
                checks++;
                if (v_cyc[i] !== xv_cyc[i] || v_req[i] !== xv_req[i] || v_tpa[i] !== xv_tpa[i]) begin
                    failures++;
                    $display("FAIL %s pkt_valid #%0d: got cyc=%0d req=%b tpa=%h want cyc=%0d req=%b tpa=%h",
                             name, i, v_cyc[i], v_req[i], v_tpa[i], xv_cyc[i], xv_req[i], xv_tpa[i]);
                end
            end
        end

        checks++;
        if (e_cyc.size() !== xe_cyc.size()) begin
            failures++;
            $display("FAIL %s pkt_error count: got %0d want %0d", name, e_cyc.size(), xe_cyc.size());
        end else begin
            for (int i = 0; i < xe_cyc.size(); i++) begin
                checks++;
                if (e_cyc[i] !== xe_cyc[i]) begin
                    failures++;
                    $display("FAIL %s pkt_error #%0d: got cyc=%0d want cyc=%0d", name, i, e_cyc[i], xe_cyc[i]);
                end
            end
        end

        want = {m_htype, m_ptype, m_oper, m_sha, m_spa, m_tha, m_tpa};
        checks++;
        if (dut_fields() !== want) begin
            failures++;
            $display("FAIL %s fields: got %h want %h", name, dut_fields(), want);
        end

        checks++;
        if (bus.busy !== 1'b0 || both_seen || stray_req) begin
            failures++;
            $display("FAIL %s idle/exclusive: got busy=%b both=%b stray_req=%b want 0 0 0",
                     name, bus.busy, both_seen, stray_req);
        end

        v_cyc.delete(); v_req.delete(); v_tpa.delete(); e_cyc.delete();
        xv_cyc.delete(); xv_req.delete(); xv_tpa.delete(); xe_cyc.delete();
        both_seen = 1'b0;
        stray_req = 1'b0;
    endtask

    function automatic pkt_t req_pkt(input logic [15:0] op);
        pkt_t w;
        w[0] = 32'h00010800;
        w[1] = {16'h0604, op};
        w[2] = 32'h00112233;
        w[3] = 32'h44550A00;
        w[4] = 32'h00010000;
        w[5] = 32'h00000000;
        w[6] = 32'h0A000002;
        return w;
    endfunction

    task automatic check_all_zero(input string name);
        checks++;
        if ({dut_fields(), bus.is_request, bus.pkt_valid, bus.pkt_error, bus.busy} !== '0) begin
            failures++;
            $display("FAIL %s outputs: got fields=%h req=%b valid=%b err=%b busy=%b want all 0",
                     name, dut_fields(), bus.is_request, bus.pkt_valid, bus.pkt_error, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        model_clear();
        finish_check("reset_release");
    endtask

    task automatic test_request();
        drive_pkt(req_pkt(16'd1), 7);
        finish_check("request");
    endtask

    task automatic test_reply();
        drive_pkt(req_pkt(16'd2), 7);
        finish_check("reply");
    endtask

    task automatic test_bad_header();
        pkt_t w;
        w = req_pkt(16'd1);
        w[0] = 32'h00060800;
        w[6] = 32'h0A0000FE;
        drive_pkt(w, 7);
        finish_check("bad_header");
        w = req_pkt(16'd3);
        drive_pkt(w, 7);
        finish_check("bad_opcode");
    endtask

    task automatic test_truncation();
        pkt_t w;
        w = req_pkt(16'd2);
        w[2] = 32'hDEADBEEF;
        drive_pkt(w, 4);
        finish_check("truncation");
        drive_pkt(w, 6);
        finish_check("truncation_w5");
    endtask

    task automatic test_overrun();
        drive_pkt(req_pkt(16'd1), 9);
        finish_check("overrun");
        drive_pkt(req_pkt(16'd2), 8);
        finish_check("overrun_short");
    endtask

    task automatic test_back_to_back();
        pkt_t w;
        w = req_pkt(16'd2);
        w[6] = local_ip;
        drive_pkt(req_pkt(16'd1), 7);
        drive_pkt(w, 7);
        drive_pkt(req_pkt(16'd1), 7);
        finish_check("back_to_back");
    endtask

    task automatic test_reset_mid();
        pkt_t w;
        w = req_pkt(16'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            bus.input_valid   = 1'b1;
            bus.input_receive = w[i];
        end
        @(posedge clk); #2;
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid busy: got %b want 1", bus.busy);
        end
        rst = 1'b1;
        bus.input_valid = 1'b0;
        #1;
        check_all_zero("reset_mid");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        finish_check("reset_mid_after");
    endtask

    task automatic test_filter();
        local_ip = 32'h0A000003;
        drive_pkt(req_pkt(16'd1), 7);
        finish_check("filter");
        local_ip = 32'h0A000002;
    endtask

    task automatic test_random();
        pkt_t w;
        int   r, n;
        for (int t = 0; t < 40; t++) begin
            w[0] = ($urandom_range(0, 3) == 0) ? $urandom : 32'h00010800;
            r    = $urandom_range(0, 5);
            w[1] = {16'h0604, (r == 0) ? 16'($urandom) : ((r < 3) ? 16'd1 : 16'd2)};
            if ($urandom_range(0, 5) == 0) w[1][31:16] = 16'($urandom);
            for (int i = 2; i < 6; i++) w[i] = $urandom;
            w[6] = ($urandom_range(0, 1) == 1) ? local_ip : $urandom;
            r = $urandom_range(0, 9);
            n = (r < 6) ? 7 : ((r < 8) ? $urandom_range(1, 6) : $urandom_range(8, 11));
            drive_pkt(w, n);
            if ($urandom_range(0, 2) != 0) finish_check("random");
        end
        finish_check("random_tail");
    endtask

    initial begin
        bus.input_valid   = 1'b0;
        bus.input_receive = '0;
        both_seen         = 1'b0;
        stray_req         = 1'b0;
        model_clear();
        test_reset();
        test_request();
        test_reply();
        test_bad_header();
        test_truncation();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_filter();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
